paddle_mover: RTL and testbench

PADDLE_MOVER -- requirements
Module: paddle_mover

---
 rtl/paddle_mover.sv | 185 ++++++++++++++++++
 tb/tb_paddle_mover.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/paddle_mover.sv
// Paddle frame sequencer: erases the paddle, waits a dwell period while the
// position steps left or right, redraws it, then pulses done. Pixels are
// emitted one per cycle in row-major order on registered outputs.
module paddle_mover #(
    parameter int          PAD_W       = 16,
    parameter int          PAD_H       = 1,
    parameter int          STEP        = 1,
    parameter int          X_MAX       = 159,
    parameter int          INIT_X      = 75,
    parameter int          Y_POS       = 110,
    parameter int          HOLD_CYCLES = 10000000,
    parameter logic [2:0]  COLOR       = 3'b111
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       go,
    input  logic       left,
    input  logic       right,
    output logic [7:0] x_out,
    output logic [6:0] y_out,
    output logic [2:0] color_out,
    output logic       plot,
    output logic       busy,
    output logic       done,
    output logic [7:0] pos_x
);

    localparam int CW = (PAD_W > 1) ? $clog2(PAD_W) : 1;
    localparam int RW = (PAD_H > 1) ? $clog2(PAD_H) : 1;
    localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

    localparam logic [CW-1:0] COL_LAST  = CW'(PAD_W - 1);
    localparam logic [RW-1:0] ROW_LAST  = RW'(PAD_H - 1);
    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);
    localparam logic [8:0]    STEP9     = 9'(STEP);
    localparam logic [8:0]    LIM9      = 9'(X_MAX - PAD_W + 1);
    localparam logic [6:0]    Y0        = 7'(Y_POS);
    localparam logic [7:0]    X_RST     = 8'(INIT_X);

    typedef enum logic [2:0] {S_IDLE, S_ERASE, S_MOVE, S_DRAW, S_DONE} state_t;
    typedef enum logic [1:0] {D_NONE, D_L, D_R} dir_t;

    state_t        state;
    dir_t          dir;
    dir_t          go_dir;
    logic [CW-1:0] col, ncol;
    logic [RW-1:0] row, nrow;
    logic [HW-1:0] hold_cnt;
    logic          first_frame;
    logic          last_px;
    logic [8:0]    sum9;
    logic [7:0]    new_x;

    // Decode the move request; both or neither held means no move.
    always_comb begin
        go_dir = D_NONE;
        if (left && !right)      go_dir = D_L;
        else if (right && !left) go_dir = D_R;
    end

    // Position after the move, clamped at both screen edges in 9-bit math.
    always_comb begin
        sum9  = {1'b0, pos_x} + STEP9;
        new_x = pos_x;
        case (dir)
            D_R:     new_x = (sum9 > LIM9) ? LIM9[7:0] : sum9[7:0];
            D_L:     new_x = ({1'b0, pos_x} >= STEP9) ? (pos_x - STEP9[7:0]) : 8'd0;
            default: new_x = pos_x;
        endcase
    end

    // Scan counter advance: column inner, row outer.
    always_comb begin
        last_px = (col == COL_LAST) && (row == ROW_LAST);
        ncol    = col + 1'b1;
        nrow    = row;
        if (col == COL_LAST) begin
            ncol = '0;
            nrow = row + 1'b1;
        end
    end

    // Frame sequencer with registered pixel/status outputs.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state       <= S_IDLE;
            dir         <= D_NONE;
            col         <= '0;
            row         <= '0;
            hold_cnt    <= '0;
            first_frame <= 1'b1;
            pos_x       <= X_RST;
            x_out       <= '0;
            y_out       <= '0;
            color_out   <= '0;
            plot        <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (go) begin
                        dir  <= go_dir;
                        col  <= '0;
                        row  <= '0;
                        busy <= 1'b1;
                        if (go_dir != D_NONE) begin
                            state     <= S_ERASE;
                            plot      <= 1'b1;
                            x_out     <= pos_x;
                            y_out     <= Y0;
                            color_out <= 3'b000;
                        end else if (first_frame) begin
                            state     <= S_DRAW;
                            plot      <= 1'b1;
                            x_out     <= pos_x;
                            y_out     <= Y0;
                            color_out <= COLOR;
                        end else begin
                            state <= S_DONE;
                            done  <= 1'b1;
                        end
                    end
                end
                S_ERASE: begin
                    if (last_px) begin
                        state    <= S_MOVE;
                        hold_cnt <= '0;
                        col      <= '0;
                        row      <= '0;
                        plot     <= 1'b0;
                        x_out    <= '0;
                        y_out    <= '0;
                    end else begin
                        col   <= ncol;
                        row   <= nrow;
                        x_out <= pos_x + 8'(ncol);
                        y_out <= Y0 + 7'(nrow);
                    end
                end
                S_MOVE: begin
                    if (hold_cnt == HOLD_LAST) begin
                        state     <= S_DRAW;
                        pos_x     <= new_x;
                        plot      <= 1'b1;
                        x_out     <= new_x;
                        y_out     <= Y0;
                        color_out <= COLOR;
                    end else begin
                        hold_cnt <= hold_cnt + 1'b1;
                    end
                end
                S_DRAW: begin
                    if (last_px) begin
                        state       <= S_DONE;
                        done        <= 1'b1;
                        first_frame <= 1'b0;
                        col         <= '0;
                        row         <= '0;
                        plot        <= 1'b0;
                        x_out       <= '0;
                        y_out       <= '0;
                        color_out   <= '0;
                    end else begin
                        col   <= ncol;
                        row   <= nrow;
                        x_out <= pos_x + 8'(ncol);
                        y_out <= Y0 + 7'(nrow);
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                    plot  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_paddle_mover.sv
// Two paddle_mover instances (single-row step-1 and two-row step-5) checked
// cycle by cycle against a per-frame expected output stream.
module tb_paddle_mover;

    typedef logic [28:0] vec_t;

    localparam int PW[2] = '{16, 16};
    localparam int PH[2] = '{1, 2};
    localparam int ST[2] = '{1, 5};
    localparam int HD[2] = '{4, 3};
    localparam int IX[2] = '{75, 78};
    localparam int XM    = 159;
    localparam int YP    = 110;

    logic       clk = 1'b0;
    logic [1:0] rst_v = 2'b00;
    logic [1:0] go_v = 2'b00, l_v = 2'b00, r_v = 2'b00;
    logic [7:0] x_o[2];
    logic [6:0] y_o[2];
    logic [2:0] c_o[2];
    logic [7:0] p_o[2];
    logic [1:0] plot_o, busy_o, done_o;

    int   nvec = 0, nerr = 0;
    vec_t q0[$], q1[$];
    int   mpos[2];
    bit   first[2];

    always #5 clk = ~clk;

    paddle_mover #(.PAD_W(16), .PAD_H(1), .STEP(1), .X_MAX(159), .INIT_X(75),
                   .Y_POS(110), .HOLD_CYCLES(4), .COLOR(3'b111)) u0 (
        .clk(clk), .resetn(rst_v[0]), .go(go_v[0]), .left(l_v[0]), .right(r_v[0]),
        .x_out(x_o[0]), .y_out(y_o[0]), .color_out(c_o[0]), .plot(plot_o[0]),
        .busy(busy_o[0]), .done(done_o[0]), .pos_x(p_o[0]));

    paddle_mover #(.PAD_W(16), .PAD_H(2), .STEP(5), .X_MAX(159), .INIT_X(78),
                   .Y_POS(110), .HOLD_CYCLES(3), .COLOR(3'b111)) u1 (
        .clk(clk), .resetn(rst_v[1]), .go(go_v[1]), .left(l_v[1]), .right(r_v[1]),
        .x_out(x_o[1]), .y_out(y_o[1]), .color_out(c_o[1]), .plot(plot_o[1]),
        .busy(busy_o[1]), .done(done_o[1]), .pos_x(p_o[1]));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        if (obs !== exp) begin
            nerr++;
            $display("FAIL %s t=%0t obs=%h exp=%h", tag, $time, obs, exp);
        end
    endtask

    function automatic vec_t pk(logic p, logic b, logic d, logic [2:0] c,
                                logic [6:0] y, logic [7:0] x, logic [7:0] px);
        return {p, b, d, c, y, x, px};
    endfunction

    function automatic int qsize(int i);
        return (i == 0) ? q0.size() : q1.size();
    endfunction

    function automatic void qpush(int i, vec_t v);
        if (i == 0) q0.push_back(v); else q1.push_back(v);
    endfunction

    function automatic vec_t qpop(int i);
        return (i == 0) ? q0.pop_front() : q1.pop_front();
    endfunction

    function automatic void qclear(int i);
        if (i == 0) q0.delete(); else q1.delete();
    endfunction

    // Expected outputs for every cycle of one frame, starting the cycle after go is taken.
    function automatic void build(int i, bit l, bit r);
        int pos = mpos[i];
        int np  = pos;
        bit mv  = (l != r);
        if (!mv && !first[i]) begin
            qpush(i, pk(0, 1, 1, 3'd0, 7'd0, 8'd0, 8'(pos)));
            return;
        end
        if (mv) begin
            for (int rr = 0; rr < PH[i]; rr++)
                for (int cc = 0; cc < PW[i]; cc++)
                    qpush(i, pk(1, 1, 0, 3'd0, 7'(YP + rr), 8'(pos + cc), 8'(pos)));
            for (int k = 0; k < HD[i]; k++)
                qpush(i, pk(0, 1, 0, 3'd0, 7'd0, 8'd0, 8'(pos)));
            if (r) np = (pos + ST[i] > XM - PW[i] + 1) ? XM - PW[i] + 1 : pos + ST[i];
            else   np = (pos < ST[i]) ? 0 : pos - ST[i];
        end
        for (int rr = 0; rr < PH[i]; rr++)
            for (int cc = 0; cc < PW[i]; cc++)
                qpush(i, pk(1, 1, 0, 3'b111, 7'(YP + rr), 8'(np + cc), 8'(np)));
        qpush(i, pk(0, 1, 1, 3'd0, 7'd0, 8'd0, 8'(np)));
        first[i] = 1'b0;
        mpos[i]  = np;
    endfunction

    // Per-cycle compare of both instances against their expected streams.
    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            vec_t obs, exp;
            obs = pk(plot_o[i], busy_o[i], done_o[i], c_o[i], y_o[i], x_o[i], p_o[i]);
            if (qsize(i) != 0) exp = qpop(i);
            else               exp = pk(0, 0, 0, 3'd0, 7'd0, 8'd0, 8'(mpos[i]));
            chk((i == 0) ? "u0_cycle" : "u1_cycle", 32'(obs), 32'(exp));
        end
    end

    task automatic issue_go(input int i, input bit l, input bit r);
        @(posedge clk); #1;
        go_v[i] = 1'b1; l_v[i] = l; r_v[i] = r;
        @(negedge clk); #1;
        build(i, l, r);
        @(posedge clk); #1;
        go_v[i] = 1'b0; l_v[i] = 1'($urandom); r_v[i] = 1'($urandom);
    endtask

    // Inputs toggle randomly while the frame runs; none of it may be taken.
    task automatic wait_idle(input int i);
        int n = 0;
        while (qsize(i) != 0 && n < 2000) begin
            go_v[i] = 1'($urandom); l_v[i] = 1'($urandom); r_v[i] = 1'($urandom);
            @(posedge clk); #1;
            n++;
        end
        go_v[i] = 1'b0;
        if (qsize(i) != 0) begin
            chk("frame_timeout", 32'd1, 32'd0);
            qclear(i);
        end
    endtask

    task automatic frame(input int i, input bit l, input bit r);
        issue_go(i, l, r);
        wait_idle(i);
    endtask

    initial begin
        for (int i = 0; i < 2; i++) begin
            mpos[i]  = IX[i];
            first[i] = 1'b1;
        end
        repeat (3) @(negedge clk);
        chk("rst_pos0", 32'(p_o[0]), 32'd75);
        chk("rst_pos1", 32'(p_o[1]), 32'd78);
        #1 rst_v = 2'b11;

        // first frame with no move only draws; then one step right
        frame(0, 0, 0);
        frame(0, 0, 1);
        chk("step_right", 32'(p_o[0]), 32'd76);
        // both buttons after first frame: straight to done
        frame(0, 1, 1);

        // right edge clamp
        while (mpos[0] != 144) frame(0, 0, 1);
        chk("at_right", 32'(p_o[0]), 32'd144);
        frame(0, 0, 1);
        chk("clamp_right", 32'(p_o[0]), 32'd144);

        // reset on the 7th erase pixel
        issue_go(0, 0, 1);
        repeat (6) @(posedge clk);
        @(negedge clk); #1;
        chk("pre_rst_plot", 32'(plot_o[0]), 32'd1);
        rst_v[0] = 1'b0;
        qclear(0);
        mpos[0]  = IX[0];
        first[0] = 1'b1;
        #1;
        chk("rst_plot", 32'(plot_o[0]), 32'd0);
        chk("rst_pos", 32'(p_o[0]), 32'd75);
        @(posedge clk);
        @(negedge clk); #1;
        rst_v[0] = 1'b1;
        frame(0, 0, 0);

        repeat (15) frame(0, 1'($urandom), 1'($urandom));

        // left edge clamp
        while (mpos[0] != 0) frame(0, 1, 0);
        frame(0, 1, 0);
        chk("clamp_left", 32'(p_o[0]), 32'd0);

        // two-row paddle, step 5: 3 -> 0 on a left move
        frame(1, 0, 0);
        while (mpos[1] != 3) frame(1, 1, 0);
        chk("at_3", 32'(p_o[1]), 32'd3);
        frame(1, 1, 0);
        chk("floor_left", 32'(p_o[1]), 32'd0);
        frame(1, 1, 0);
        repeat (20) frame(1, 1'($urandom), 1'($urandom));

        repeat (3) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
